// File: rtl/vga_pkg.sv
// Shared VGA timing constants, mode presets and helpers for the timing generator.
// Counters are classified into active / front porch / sync / back porch segments.
package vga_pkg;

  typedef struct packed {
    logic [15:0] active;
    logic [15:0] front;
    logic [15:0] sync;
    logic [15:0] back;
  } vga_axis_t;

  localparam vga_axis_t H_640X480 = '{active: 16'd640, front: 16'd16, sync: 16'd96,  back: 16'd48};
  localparam vga_axis_t V_640X480 = '{active: 16'd480, front: 16'd10, sync: 16'd2,   back: 16'd33};
  localparam vga_axis_t H_800X600 = '{active: 16'd800, front: 16'd40, sync: 16'd128, back: 16'd88};
  localparam vga_axis_t V_800X600 = '{active: 16'd600, front: 16'd1,  sync: 16'd4,   back: 16'd23};

  localparam int DEF_CLK_DIV = 2;
  localparam int DEF_CW      = 11;

  typedef enum logic [1:0] {
    SEG_ACTIVE,
    SEG_FRONT,
    SEG_SYNC,
    SEG_BACK
  } seg_e;

  function automatic int h_total(int active, int front, int sync, int back);
    return active + front + sync + back;
  endfunction

  function automatic int v_total(int active, int front, int sync, int back);
    return active + front + sync + back;
  endfunction

  // Line/frame order is active, front porch, sync, back porch.
  function automatic seg_e seg_of(int cnt, int active, int front, int sync);
    if (cnt < active)                    return SEG_ACTIVE;
    else if (cnt < active + front)       return SEG_FRONT;
    else if (cnt < active + front + sync) return SEG_SYNC;
    return SEG_BACK;
  endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel prescaler: counts 0..CLK_DIV-1 while enabled, ticks on the last count.
module vga_pix_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA sync/blanking generator: pixel-rate h/v counters decoded into registered,
// mutually aligned sync, data-enable, position and start-of-line/frame pulses.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = int'(H_640X480.active),
  parameter int H_FRONT  = int'(H_640X480.front),
  parameter int H_SYNC   = int'(H_640X480.sync),
  parameter int H_BACK   = int'(H_640X480.back),
  parameter int V_ACTIVE = int'(V_640X480.active),
  parameter int V_FRONT  = int'(V_640X480.front),
  parameter int V_SYNC   = int'(V_640X480.sync),
  parameter int V_BACK   = int'(V_640X480.back),
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int CW       = DEF_CW
) (
  input  logic          vga_CLK,
  input  logic          vga_RST_n,
  input  logic          vga_EN,
  output logic          vga_HS,
  output logic          vga_VS,
  output logic          vga_Ready,
  output logic [CW-1:0] pos_H,
  output logic [CW-1:0] pos_V,
  output logic          pix_Tick,
  output logic          line_Start,
  output logic          frame_Start
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be in 1..16");
  end
  if (H_TOTAL > (2 ** CW) - 1) begin : g_bad_h
    $error("vga_timing_gen: horizontal total does not fit in CW bits");
  end
  if (V_TOTAL > (2 ** CW) - 1) begin : g_bad_v
    $error("vga_timing_gen: vertical total does not fit in CW bits");
  end

  logic tick;

  vga_pix_div #(
    .CLK_DIV(CLK_DIV)
  ) u_pix_div (
    .clk   (vga_CLK),
    .rst_n (vga_RST_n),
    .enable(vga_EN),
    .tick  (tick)
  );

  logic [CW-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [CW-1:0] pos_h_q, pos_h_d, pos_v_q, pos_v_d;
  logic          hs_q, hs_d, vs_q, vs_d, ready_q, ready_d;
  logic          pix_tick_q, pix_tick_d, line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  seg_e          h_seg, v_seg;

  always_comb begin
    h_seg = seg_of(int'(h_cnt_q), H_ACTIVE, H_FRONT, H_SYNC);
    v_seg = seg_of(int'(v_cnt_q), V_ACTIVE, V_FRONT, V_SYNC);

    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end

    // Level outputs freeze while disabled so a pause is invisible downstream.
    hs_d    = hs_q;
    vs_d    = vs_q;
    ready_d = ready_q;
    pos_h_d = pos_h_q;
    pos_v_d = pos_v_q;
    if (vga_EN) begin
      hs_d    = (h_seg == SEG_SYNC) ? HS_POL : ~HS_POL;
      vs_d    = (v_seg == SEG_SYNC) ? VS_POL : ~VS_POL;
      ready_d = (h_seg == SEG_ACTIVE) && (v_seg == SEG_ACTIVE);
      if (ready_d) begin
        pos_h_d = h_cnt_q;
        pos_v_d = v_cnt_q;
      end
    end

    pix_tick_d    = tick;
    line_start_d  = tick && (h_cnt_q == '0);
    frame_start_d = line_start_d && (v_cnt_q == '0);
  end

  always_ff @(posedge vga_CLK or negedge vga_RST_n) begin
    if (!vga_RST_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      pos_h_q       <= '0;
      pos_v_q       <= '0;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      ready_q       <= 1'b0;
      pix_tick_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      pos_h_q       <= pos_h_d;
      pos_v_q       <= pos_v_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      ready_q       <= ready_d;
      pix_tick_q    <= pix_tick_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga_HS      = hs_q;
  assign vga_VS      = vs_q;
  assign vga_Ready   = ready_q;
  assign pos_H       = pos_h_q;
  assign pos_V       = pos_v_q;
  assign pix_Tick    = pix_tick_q;
  assign line_Start  = line_start_q;
  assign frame_Start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations (default 640x480/div2, tiny
// positive-polarity div1, tiny negative-polarity div3) against a pixel-index model.
module tb_vga_timing_gen;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, hpol, vpol, div;
  } cfg_t;

  function automatic cfg_t get_cfg(int i);
    cfg_t c;
    case (i)
      0:       c = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 2};
      1:       c = '{8, 2, 3, 2, 5, 1, 2, 1, 1, 1, 1};
      default: c = '{6, 1, 2, 3, 4, 2, 1, 2, 0, 0, 3};
    endcase
    return c;
  endfunction

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en     [3];
  logic        hs_o   [3];
  logic        vs_o   [3];
  logic        rdy_o  [3];
  logic        pix_o  [3];
  logic        line_o [3];
  logic        frame_o[3];
  logic [10:0] ph_o   [3];
  logic [10:0] pv_o   [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut_a (
    .vga_CLK(clk), .vga_RST_n(rst_n), .vga_EN(en[0]),
    .vga_HS(hs_o[0]), .vga_VS(vs_o[0]), .vga_Ready(rdy_o[0]),
    .pos_H(ph_o[0]), .pos_V(pv_o[0]),
    .pix_Tick(pix_o[0]), .line_Start(line_o[0]), .frame_Start(frame_o[0])
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(5), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1), .CW(11)
  ) dut_b (
    .vga_CLK(clk), .vga_RST_n(rst_n), .vga_EN(en[1]),
    .vga_HS(hs_o[1]), .vga_VS(vs_o[1]), .vga_Ready(rdy_o[1]),
    .pos_H(ph_o[1]), .pos_V(pv_o[1]),
    .pix_Tick(pix_o[1]), .line_Start(line_o[1]), .frame_Start(frame_o[1])
  );

  vga_timing_gen #(
    .H_ACTIVE(6), .H_FRONT(1), .H_SYNC(2), .H_BACK(3),
    .V_ACTIVE(4), .V_FRONT(2), .V_SYNC(1), .V_BACK(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(3), .CW(11)
  ) dut_c (
    .vga_CLK(clk), .vga_RST_n(rst_n), .vga_EN(en[2]),
    .vga_HS(hs_o[2]), .vga_VS(vs_o[2]), .vga_Ready(rdy_o[2]),
    .pos_H(ph_o[2]), .pos_V(pv_o[2]),
    .pix_Tick(pix_o[2]), .line_Start(line_o[2]), .frame_Start(frame_o[2])
  );

  // Output bundle: {HS, VS, Ready, pix_Tick, line_Start, frame_Start, pos_H, pos_V}
  function automatic logic [27:0] get_obs(int i);
    return {hs_o[i], vs_o[i], rdy_o[i], pix_o[i], line_o[i], frame_o[i], ph_o[i], pv_o[i]};
  endfunction

  function automatic logic [27:0] reset_vec(int i);
    cfg_t c = get_cfg(i);
    return {(c.hpol == 0), (c.vpol == 0), 1'b0, 3'b000, 22'd0};
  endfunction

  task automatic apply_reset();
    for (int i = 0; i < 3; i++) en[i] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [27:0] obs;
    for (int i = 0; i < 3; i++) en[i] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      obs = get_obs(i);
      checks++;
      if (obs !== reset_vec(i)) begin
        errors++;
        $display("FAIL reset_values inst%0d: got %07h expected %07h", i, obs, reset_vec(i));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      obs = get_obs(i);
      checks++;
      if (obs !== reset_vec(i)) begin
        errors++;
        $display("FAIL disabled_after_reset inst%0d: got %07h expected %07h", i, obs, reset_vec(i));
      end
    end
    $display("test_reset done");
  endtask

  // Model: the k-th enabled edge after reset shows pixel floor(k/div) in raster order.
  task automatic test_random_run(int i, int n);
    cfg_t        c = get_cfg(i);
    int          ht = c.ha + c.hf + c.hs + c.hb;
    int          vt = c.va + c.vf + c.vs + c.vb;
    int          cnt = 0;
    int          k, p, h, v, ph_e, pv_e;
    logic        e, hs_e, vs_e, rdy_e, pix_e, line_e, frame_e;
    logic [27:0] exp_v, obs;
    apply_reset();
    hs_e = (c.hpol == 0);
    vs_e = (c.vpol == 0);
    rdy_e = 1'b0;
    ph_e = 0;
    pv_e = 0;
    for (int t = 0; t < n; t++) begin
      e = ($urandom_range(0, 3) != 0);
      en[i] = e;
      @(posedge clk);
      #1;
      pix_e = 1'b0;
      line_e = 1'b0;
      frame_e = 1'b0;
      if (e) begin
        k = cnt;
        cnt++;
        p = k / c.div;
        h = p % ht;
        v = (p / ht) % vt;
        hs_e = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) ? (c.hpol != 0) : (c.hpol == 0);
        vs_e = (v >= c.va + c.vf && v < c.va + c.vf + c.vs) ? (c.vpol != 0) : (c.vpol == 0);
        rdy_e = (h < c.ha) && (v < c.va);
        if (rdy_e) begin
          ph_e = h;
          pv_e = v;
        end
        pix_e = ((k % c.div) == c.div - 1);
        line_e = pix_e && (h == 0);
        frame_e = line_e && (v == 0);
      end
      exp_v = {hs_e, vs_e, rdy_e, pix_e, line_e, frame_e, 11'(ph_e), 11'(pv_e)};
      obs = get_obs(i);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL rand_run inst%0d t=%0d: got %07h expected %07h", i, t, obs, exp_v);
      end
    end
    en[i] = 1'b0;
    $display("test_random_run inst%0d: %0d cycles, %0d enabled", i, n, cnt);
  endtask

  task automatic test_hsync_default();
    int first_low = -1, low_run = 0, rdy_cnt = 0, line_cnt = 0, frame_cnt = 0;
    int pix_cnt = 0, vs_low = 0;
    apply_reset();
    en[0] = 1'b1;
    for (int cyc = 1; cyc <= 3200; cyc++) begin
      @(posedge clk);
      #1;
      if (hs_o[0] == 1'b0) begin
        if (first_low < 0) first_low = cyc;
        if (cyc <= 1600) low_run++;
      end
      if (rdy_o[0] && cyc <= 1600) rdy_cnt++;
      if (line_o[0]) line_cnt++;
      if (frame_o[0]) frame_cnt++;
      if (pix_o[0]) pix_cnt++;
      if (vs_o[0] == 1'b0) vs_low++;
    end
    en[0] = 1'b0;
    checks++;
    if (first_low != 1313) begin errors++; $display("FAIL hs_start: got %0d required 1313", first_low); end
    checks++;
    if (low_run != 192) begin errors++; $display("FAIL hs_width: got %0d required 192", low_run); end
    checks++;
    if (rdy_cnt != 1280) begin errors++; $display("FAIL ready_per_line: got %0d required 1280", rdy_cnt); end
    checks++;
    if (line_cnt != 2) begin errors++; $display("FAIL line_start_count: got %0d required 2", line_cnt); end
    checks++;
    if (frame_cnt != 1) begin errors++; $display("FAIL frame_start_count: got %0d required 1", frame_cnt); end
    checks++;
    if (pix_cnt != 1600) begin errors++; $display("FAIL pix_tick_count: got %0d required 1600", pix_cnt); end
    checks++;
    if (vs_low != 0) begin errors++; $display("FAIL vs_idle: got %0d low cycles required 0", vs_low); end
    $display("test_hsync_default: hs low from cycle %0d for %0d cycles", first_low, low_run);
  endtask

  task automatic test_en_hold();
    logic [27:0] snap, obs;
    int          ticks = 0;
    bit          found = 0;
    apply_reset();
    en[0] = 1'b1;
    for (int t = 0; t < 1000 && !found; t++) begin
      @(posedge clk);
      #1;
      if (ph_o[0] == 11'd100) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL hold_reach_100: got pos_H=%0d required 100", ph_o[0]);
    end
    en[0] = 1'b0;
    snap = get_obs(0) & ~28'h0700000;
    for (int t = 0; t < 37; t++) begin
      @(posedge clk);
      #1;
      obs = get_obs(0);
      checks++;
      if (obs !== snap) begin
        errors++;
        $display("FAIL en_hold t=%0d: got %07h expected %07h", t, obs, snap);
      end
    end
    en[0] = 1'b1;
    found = 0;
    for (int t = 0; t < 10 && !found; t++) begin
      @(posedge clk);
      #1;
      if (pix_o[0]) ticks++;
      if (ph_o[0] != 11'd100) found = 1;
    end
    en[0] = 1'b0;
    checks++;
    if (ph_o[0] !== 11'd101) begin errors++; $display("FAIL resume_pos: got %0d required 101", ph_o[0]); end
    checks++;
    if (ticks != 1) begin errors++; $display("FAIL resume_ticks: got %0d required 1", ticks); end
    $display("test_en_hold: resumed at pos_H=%0d after %0d tick", ph_o[0], ticks);
  endtask

  task automatic test_async_reset(int i);
    logic [27:0] obs;
    bit          found = 0;
    apply_reset();
    en[i] = 1'b1;
    for (int t = 0; t < 1000 && !found; t++) begin
      @(posedge clk);
      #1;
      if (pv_o[i] == 11'd3) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL areset_reach_row inst%0d: got pos_V=%0d required 3", i, pv_o[i]); end
    #2;
    rst_n = 1'b0;
    #1;
    obs = get_obs(i);
    checks++;
    if (obs !== reset_vec(i)) begin
      errors++;
      $display("FAIL async_reset inst%0d: got %07h expected %07h", i, obs, reset_vec(i));
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    found = 0;
    for (int t = 0; t < 10 && !found; t++) begin
      @(posedge clk);
      #1;
      if (pix_o[i]) found = 1;
    end
    en[i] = 1'b0;
    checks++;
    if (!(found && frame_o[i] && line_o[i])) begin
      errors++;
      $display("FAIL first_tick_frame inst%0d: got tick=%0b frame=%0b line=%0b required 1 1 1",
               i, found, frame_o[i], line_o[i]);
    end
    $display("test_async_reset inst%0d: frame_Start on first tick = %0b", i, frame_o[i]);
  endtask

  task automatic test_frame_period(int i);
    cfg_t c = get_cfg(i);
    int   period = (c.ha + c.hf + c.hs + c.hb) * (c.va + c.vf + c.vs + c.vb) * c.div;
    int   first = -1, second = -1;
    logic line_at_wrap = 1'b0;
    apply_reset();
    en[i] = 1'b1;
    for (int t = 0; t < 3 * period + 10 && second < 0; t++) begin
      @(posedge clk);
      #1;
      if (frame_o[i]) begin
        if (first < 0) first = t;
        else begin
          second = t;
          line_at_wrap = line_o[i];
        end
      end
    end
    en[i] = 1'b0;
    checks++;
    if (second - first != period || first < 0 || second < 0) begin
      errors++;
      $display("FAIL frame_period inst%0d: got %0d required %0d", i, second - first, period);
    end
    checks++;
    if (line_at_wrap !== 1'b1) begin
      errors++;
      $display("FAIL wrap_line_start inst%0d: got %0b required 1", i, line_at_wrap);
    end
    $display("test_frame_period inst%0d: period %0d cycles", i, second - first);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) en[i] = 1'b0;
    test_reset();
    test_random_run(1, 600);
    test_random_run(2, 1500);
    test_random_run(0, 4000);
    test_hsync_default();
    test_en_hold();
    test_async_reset(1);
    test_async_reset(2);
    test_frame_period(1);
    test_frame_period(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HS_POL, 0, asserted level of vga_HS (0 = active-low)
- VS_POL, 0, asserted level of vga_VS
- CLK_DIV, 2, vga_CLK cycles per pixel (1..16)
- CW, 11, counter and position width
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- vga_CLK, in, 1, single clock
- vga_RST_n, in, 1, asynchronous active-low reset
- vga_EN, in, 1, run enable; low freezes timing
- vga_HS, out, 1, horizontal sync
- vga_VS, out, 1, vertical sync
- vga_Ready, out, 1, data enable (visible pixel)
- pos_H, out, CW, visible column, 0..H_ACTIVE-1
- pos_V, out, CW, visible row, 0..V_ACTIVE-1
- pix_Tick, out, 1, one-cycle pulse per pixel period
- line_Start, out, 1, pulse on first pixel of every line
- frame_Start, out, 1, pulse on pixel (0,0) of every frame

Function
REQ-003 A prescaler SHALL count 0..CLK_DIV-1 while vga_EN=1 and assert an internal tick when it equals CLK_DIV-1; CLK_DIV=1 ticks every cycle.
REQ-004 h_cnt SHALL advance only on tick and wrap from H_TOTAL-1 (H_ACTIVE+H_FRONT+H_SYNC+H_BACK) to 0.
REQ-005 v_cnt SHALL advance only on a tick where h_cnt wraps, and wrap from V_TOTAL-1 to 0 at that same tick.
REQ-006 Line order SHALL be active, front porch, sync, back porch; vga_HS SHALL equal HS_POL when H_ACTIVE+H_FRONT <= h_cnt < H_ACTIVE+H_FRONT+H_SYNC, else !HS_POL; vga_VS likewise on v_cnt.
REQ-007 vga_Ready SHALL be 1 iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-008 pos_H/pos_V SHALL equal h_cnt/v_cnt while vga_Ready=1 and hold their last values otherwise.
REQ-009 line_Start SHALL pulse when h_cnt=0, and frame_Start when h_cnt=0 and v_cnt=0, each for exactly the single cycle coinciding with pix_Tick.
REQ-010 All outputs SHALL be registered and mutually aligned: one vga_CLK after the counter state they decode.
REQ-011 vga_EN=0 SHALL hold the prescaler, counters and all level outputs; pix_Tick, line_Start and frame_Start SHALL be 0. Resumption SHALL continue from the held state without skipping or repeating a pixel.
REQ-012 Counter arithmetic SHALL be CW bits; totals exceeding 2**CW-1 SHALL be a parameter-check error at elaboration.

Reset
REQ-013 vga_RST_n=0 SHALL asynchronously clear the prescaler, h_cnt, v_cnt, pos_H, pos_V, vga_Ready and all pulses, and set vga_HS=!HS_POL and vga_VS=!VS_POL.
REQ-014 Mid-frame reset SHALL abandon the frame; after release the first tick SHALL produce frame_Start.

Structure
REQ-015 A shared package vga_pkg SHALL hold the default timing constants, H_TOTAL/V_TOTAL derivation functions, and the 640x480 and 800x600 presets.
REQ-016 The prescaler SHALL be the sub-module vga_pix_div (input enable, output tick); the remainder stays in vga_timing_gen.

Verification
REQ-017 Defaults, EN=1: frame_Start period = 800*525*2 = 840000 cycles; vga_Ready high 640 ticks per line on 480 lines.
REQ-018 Defaults: vga_HS low for exactly 96 ticks starting at h_cnt=656; vga_VS low for 2 lines starting at v_cnt=490.
REQ-019 HS_POL=1, VS_POL=1, CLK_DIV=1: sync pulses high; after reset HS=VS=0; pix_Tick constant 1.
REQ-020 vga_EN dropped for 37 cycles at pos_H=100: outputs hold, no pulses; after resumption pos_H continues at 101.
REQ-021 Reset asserted at v_cnt=300: outputs reach reset values with no clock edge; frame_Start pulses on the first tick after release.
REQ-022 At the last pixel (h_cnt=799, v_cnt=524) the next tick wraps both counters, and frame_Start and line_Start pulse together.
